fifo_sync_lvl: RTL and testbench

Single-clock, parametrised successor to the dual-clock pointer-handler FIFO. It buffers data between H.264 pipeline stages that share one clock domain, such as intra-prediction to transform/quant and the CAVLC bitstream packer. It adds several features over the async FIFO:
- arbitrary (non-power-of-2) depth
- exact fill level output
- programmable almost-full / almost-empty flags
- registered read port with a valid strobe
- synchronous flush

---
 rtl/fifo_sync_lvl.sv | 170 +++++++++++++++++
 tb/tb_fifo_sync_lvl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_lvl.sv
// fifo_sync_lvl: single-clock FIFO with arbitrary depth, exact fill level,
// programmable almost-full/almost-empty flags, a registered read port with
// a valid strobe, and a synchronous flush.
// Optional sticky overflow/underflow error flags are enabled by defining
// the macro FIFO_SYNC_LVL_ERR_EN.
module fifo_sync_lvl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AFULL_TH   = DEPTH - 1,
    parameter int AEMPTY_TH  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         wr_en_i,
    input  logic [DATA_WIDTH-1:0]        wr_data_i,
    output logic                         wr_full_o,
    output logic                         wr_almost_full_o,
    input  logic                         rd_en_i,
    output logic [DATA_WIDTH-1:0]        rd_data_o,
    output logic                         rd_valid_o,
    output logic                         rd_empty_o,
    output logic                         rd_almost_empty_o,
`ifdef FIFO_SYNC_LVL_ERR_EN
    output logic                         err_ovf_o,
    output logic                         err_unf_o,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   level_o
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);

    localparam logic [PTR_WIDTH-1:0] PTR_LAST  = PTR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL  = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_AFULL = CNT_WIDTH'(AFULL_TH);
    localparam logic [CNT_WIDTH-1:0] CNT_AEMPT = CNT_WIDTH'(AEMPTY_TH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE   = PTR_WIDTH'(1);

    // Reject illegal configurations at elaboration time
    if (DEPTH < 2) begin : g_errDepth
        $error("fifo_sync_lvl: DEPTH must be at least 2");
    end
    if ((AFULL_TH < 1) || (AFULL_TH > DEPTH)) begin : g_errAfull
        $error("fifo_sync_lvl: AFULL_TH must lie in 1..DEPTH");
    end
    if ((AEMPTY_TH < 0) || (AEMPTY_TH > DEPTH - 1)) begin : g_errAempty
        $error("fifo_sync_lvl: AEMPTY_TH must lie in 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_WIDTH-1:0]  wrPtr_q,  wrPtr_d;
    logic [PTR_WIDTH-1:0]  rdPtr_q,  rdPtr_d;
    logic [CNT_WIDTH-1:0]  level_q,  level_d;
    logic [DATA_WIDTH-1:0] rdData_q, rdData_d;
    logic                  rdValid_q, rdValid_d;

    logic isFull;
    logic isEmpty;
    logic wrAcc;
    logic rdAcc;

    // Status decodes come straight from the registered level
    assign isFull  = (level_q == CNT_FULL);
    assign isEmpty = (level_q == '0);

    // Flush blocks both ports; full/empty gate each port independently
    assign wrAcc = wr_en_i && !isFull  && !flush_i;
    assign rdAcc = rd_en_i && !isEmpty && !flush_i;

    // Next-state for pointers, level and the registered read port
    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        level_d   = level_q;
        rdData_d  = rdData_q;
        rdValid_d = 1'b0;

        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            level_d = '0;
        end else begin
            if (wrAcc) begin
                wrPtr_d = (wrPtr_q == PTR_LAST) ? '0 : wrPtr_q + PTR_ONE;
            end
            if (rdAcc) begin
                rdPtr_d   = (rdPtr_q == PTR_LAST) ? '0 : rdPtr_q + PTR_ONE;
                rdData_d  = mem_q[rdPtr_q];
                rdValid_d = 1'b1;
            end
            case ({wrAcc, rdAcc})
                2'b10:   level_d = level_q + CNT_ONE;
                2'b01:   level_d = level_q - CNT_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            level_q   <= '0;
            rdData_q  <= '0;
            rdValid_q <= 1'b0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            level_q   <= level_d;
            rdData_q  <= rdData_d;
            rdValid_q <= rdValid_d;
        end
    end

    // Storage array is never reset or cleared, only overwritten
    always_ff @(posedge clk) begin
        if (wrAcc) begin
            mem_q[wrPtr_q] <= wr_data_i;
        end
    end

`ifdef FIFO_SYNC_LVL_ERR_EN
    logic errOvf_q, errOvf_d;
    logic errUnf_q, errUnf_d;

    // Sticky error flags; a write racing a read on a full FIFO is not overflow
    always_comb begin
        errOvf_d = errOvf_q;
        errUnf_d = errUnf_q;
        if (flush_i) begin
            errOvf_d = 1'b0;
            errUnf_d = 1'b0;
        end else begin
            if (wr_en_i && isFull && !rdAcc) begin
                errOvf_d = 1'b1;
            end
            if (rd_en_i && isEmpty) begin
                errUnf_d = 1'b1;
            end
        end
    end

    // Error flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errOvf_q <= 1'b0;
            errUnf_q <= 1'b0;
        end else begin
            errOvf_q <= errOvf_d;
            errUnf_q <= errUnf_d;
        end
    end

    assign err_ovf_o = errOvf_q;
    assign err_unf_o = errUnf_q;
`endif

    assign wr_full_o         = isFull;
    assign wr_almost_full_o  = (level_q >= CNT_AFULL);
    assign rd_empty_o        = isEmpty;
    assign rd_almost_empty_o = (level_q <= CNT_AEMPT);
    assign rd_data_o         = rdData_q;
    assign rd_valid_o        = rdValid_q;
    assign level_o           = level_q;

endmodule

// File: tb/tb_fifo_sync_lvl.sv
// tb_fifo_sync_lvl: directed self-checking bench for fifo_sync_lvl with
// DEPTH=5, DATA_WIDTH=8, AFULL_TH=4, AEMPTY_TH=1.
// Error-flag scenarios are included when FIFO_SYNC_LVL_ERR_EN is defined.
module tb_fifo_sync_lvl;

    logic       clk;
    logic       rst_n;
    logic       flush_i;
    logic       wr_en_i;
    logic [7:0] wr_data_i;
    logic       wr_full_o;
    logic       wr_almost_full_o;
    logic       rd_en_i;
    logic [7:0] rd_data_o;
    logic       rd_valid_o;
    logic       rd_empty_o;
    logic       rd_almost_empty_o;
    logic [2:0] level_o;
`ifdef FIFO_SYNC_LVL_ERR_EN
    logic       err_ovf_o;
    logic       err_unf_o;
`endif

    int checkCount = 0;
    int passCount  = 0;

    fifo_sync_lvl #(
        .DATA_WIDTH (8),
        .DEPTH      (5),
        .AFULL_TH   (4),
        .AEMPTY_TH  (1)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush_i           (flush_i),
        .wr_en_i           (wr_en_i),
        .wr_data_i         (wr_data_i),
        .wr_full_o         (wr_full_o),
        .wr_almost_full_o  (wr_almost_full_o),
        .rd_en_i           (rd_en_i),
        .rd_data_o         (rd_data_o),
        .rd_valid_o        (rd_valid_o),
        .rd_empty_o        (rd_empty_o),
        .rd_almost_empty_o (rd_almost_empty_o),
`ifdef FIFO_SYNC_LVL_ERR_EN
        .err_ovf_o         (err_ovf_o),
        .err_unf_o         (err_unf_o),
`endif
        .level_o           (level_o)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count a comparison and report it when observed differs from expected
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then settle after the rising edge
    task automatic applyStimulus(input logic wr, input logic [7:0] data, input logic rd, input logic fl);
        @(negedge clk);
        wr_en_i   = wr;
        wr_data_i = data;
        rd_en_i   = rd;
        flush_i   = fl;
        @(posedge clk);
        #1;
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        flush_i = 1'b0;
    endtask

    // Check the full status picture for a given level
    task automatic checkLevel(input string tag, input int lvl);
        checkOutput({tag, " level"},  32'(level_o),           32'(lvl));
        checkOutput({tag, " full"},   32'(wr_full_o),         32'(lvl == 5));
        checkOutput({tag, " afull"},  32'(wr_almost_full_o),  32'(lvl >= 4));
        checkOutput({tag, " empty"},  32'(rd_empty_o),        32'(lvl == 0));
        checkOutput({tag, " aempty"}, 32'(rd_almost_empty_o), 32'(lvl <= 1));
    endtask

    // Check the read port after a cycle
    task automatic checkRead(input string tag, input logic vld, input logic [7:0] data);
        checkOutput({tag, " valid"}, 32'(rd_valid_o), 32'(vld));
        checkOutput({tag, " data"},  32'(rd_data_o),  32'(data));
    endtask

    logic [7:0] fillData [5];
    logic [7:0] wrapData [5];

    initial begin
        fillData = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        wrapData = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};

        rst_n     = 1'b0;
        flush_i   = 1'b0;
        wr_en_i   = 1'b0;
        wr_data_i = 8'h00;
        rd_en_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        checkLevel("reset", 0);
        checkRead("reset", 1'b0, 8'h00);
`ifdef FIFO_SYNC_LVL_ERR_EN
        checkOutput("reset err_ovf", 32'(err_ovf_o), 32'd0);
        checkOutput("reset err_unf", 32'(err_unf_o), 32'd0);
`endif

        // Fill to full, then one dropped write
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, fillData[i], 1'b0, 1'b0);
            checkLevel($sformatf("fill%0d", i), i + 1);
            checkOutput($sformatf("fill%0d valid", i), 32'(rd_valid_o), 32'd0);
        end
        applyStimulus(1'b1, 8'h66, 1'b0, 1'b0);
        checkLevel("fillDrop", 5);

        // Drain, sixth read ignored; 0x66 must not appear
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkRead($sformatf("drain%0d", i), 1'b1, fillData[i]);
            checkLevel($sformatf("drain%0d", i), 4 - i);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkRead("drainExtra", 1'b0, 8'h55);
        checkLevel("drainExtra", 0);

        // Wrap: offset pointers by 3, then push 5 across the wrap point
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'(i + 1), 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkRead($sformatf("pre%0d", i), 1'b1, 8'(i + 1));
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, wrapData[i], 1'b0, 1'b0);
        end
        checkLevel("wrapFull", 5);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkRead($sformatf("wrap%0d", i), 1'b1, wrapData[i]);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkRead("wrapIdle", 1'b0, 8'hA4);
        checkLevel("wrapIdle", 0);

        // Simultaneous read/write at mid level keeps level and order
        applyStimulus(1'b1, 8'hB0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hB1, 1'b0, 1'b0);
        checkLevel("simPre", 2);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
            checkRead($sformatf("sim%0d", i), 1'b1, (i < 2) ? 8'(8'hB0 + i) : 8'(8'hC0 + i - 2));
            checkLevel($sformatf("sim%0d", i), 2);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkRead("simTail0", 1'b1, 8'hC2);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkRead("simTail1", 1'b1, 8'hC3);
        checkLevel("simTail1", 0);

        // Both at empty: write only, no valid strobe
        applyStimulus(1'b1, 8'hD0, 1'b1, 1'b0);
        checkRead("simEmpty", 1'b0, 8'hC3);
        checkLevel("simEmpty", 1);

        // Both at full: read only, write dropped
        for (int i = 1; i < 5; i++) begin
            applyStimulus(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
        end
        checkLevel("simFullPre", 5);
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
        checkRead("simFull", 1'b1, 8'hD0);
        checkLevel("simFull", 4);
        for (int i = 1; i < 5; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkRead($sformatf("simFullDrain%0d", i), 1'b1, 8'(8'hE0 + i));
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkRead("simFullDrainEnd", 1'b0, 8'hE4);
        checkLevel("simFullDrainEnd", 0);

        // Flush at level 3 with a read just before and a write during it
        for (int i = 1; i < 5; i++) begin
            applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkRead("preFlush", 1'b1, 8'h31);
        checkLevel("preFlush", 3);
        applyStimulus(1'b1, 8'h99, 1'b1, 1'b1);
        checkRead("flush", 1'b0, 8'h31);
        checkLevel("flush", 0);
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
        checkLevel("postFlushWr", 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkRead("postFlushRd", 1'b1, 8'h77);
        checkLevel("postFlushRd", 0);

        // Reset mid-stream discards contents
        applyStimulus(1'b1, 8'h81, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h82, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checkLevel("midReset", 0);
        checkRead("midReset", 1'b0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkRead("postReset", 1'b1, 8'h5A);
        checkLevel("postReset", 0);

`ifdef FIFO_SYNC_LVL_ERR_EN
        // Sticky error flags: underflow, overflow, then flush clears both
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("unf set", 32'(err_unf_o), 32'd1);
        checkOutput("unf ovf", 32'(err_ovf_o), 32'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
        end
        checkOutput("full no ovf", 32'(err_ovf_o), 32'd0);
        applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
        checkOutput("wr+rd full no ovf", 32'(err_ovf_o), 32'd0);
        applyStimulus(1'b1, 8'h04, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        checkOutput("ovf set", 32'(err_ovf_o), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("ovf hold", 32'(err_ovf_o), 32'd1);
        checkOutput("unf hold", 32'(err_unf_o), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("flush ovf", 32'(err_ovf_o), 32'd0);
        checkOutput("flush unf", 32'(err_unf_o), 32'd0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
